// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and the flag bundle decoded per pixel.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned CNT_W    = 10;

  // Per-pixel decode results, registered together so they stay aligned with x/y.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic line_start;
    logic frame_start;
    logic vblank_start;
  } vga_flags_t;

  // True when a w-bit counter can hold every value 0..total-1.
  function automatic bit cnt_w_fits(input int unsigned w, input int unsigned total);
    return (w > 0) && (w < 32) && ((64'd1 << w) >= 64'(total));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter for one raster axis; wrap flags the increment that returns to 0.
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign wrap  = inc && (count_q == LAST);
  assign count = count_q;

  // Next count: advance on inc, fold back to zero after the last position.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters, sync/de/strobe decode, one aligned output register stage.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = vga_pkg::CNT_W
) (
  input  logic             clk_25_175,
  input  logic             rst_n,
  input  logic             ena,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: every timing parameter must be non-zero");
  end

  if (!cnt_w_fits(CNT_W, H_TOT) || !cnt_w_fits(CNT_W, V_TOT)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for H/V totals");
  end

  localparam logic [CNT_W-1:0] H_ACT_L  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_L  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_flags_t FLAGS_RST = '{
    hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0,
    line_start: 1'b0, frame_start: 1'b0, vblank_start: 1'b0
  };

  logic [CNT_W-1:0] hc, vc;
  logic             h_wrap;
  logic             v_wrap_unused;

  vga_axis_counter #(.TOTAL(H_TOT), .CNT_W(CNT_W)) u_h_axis (
    .clk   (clk_25_175),
    .rst_n (rst_n),
    .inc   (ena),
    .count (hc),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOT), .CNT_W(CNT_W)) u_v_axis (
    .clk   (clk_25_175),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .count (vc),
    .wrap  (v_wrap_unused)
  );

  vga_flags_t       flags_d, flags_q;
  logic [CNT_W-1:0] x_q, y_q;

  // Decode syncs, display enable and strobes for the pixel the counters point at.
  always_comb begin
    flags_d              = FLAGS_RST;
    flags_d.hsync        = ((hc >= HS_START) && (hc < HS_END)) ? SYNC_POL : ~SYNC_POL;
    flags_d.vsync        = ((vc >= VS_START) && (vc < VS_END)) ? SYNC_POL : ~SYNC_POL;
    flags_d.de           = (hc < H_ACT_L) && (vc < V_ACT_L);
    flags_d.line_start   = (hc == '0);
    flags_d.frame_start  = (hc == '0) && (vc == '0);
    flags_d.vblank_start = (hc == '0) && (vc == V_ACT_L);
  end

  // Output stage: capture decode and coordinates together; when frozen, hold levels and kill
  // strobes so a held pixel never reports its strobe twice.
  always_ff @(posedge clk_25_175 or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
      x_q     <= '0;
      y_q     <= '0;
    end else if (ena) begin
      flags_q <= flags_d;
      x_q     <= hc;
      y_q     <= vc;
    end else begin
      flags_q.line_start   <= 1'b0;
      flags_q.frame_start  <= 1'b0;
      flags_q.vblank_start <= 1'b0;
    end
  end

  assign hsync        = flags_q.hsync;
  assign vsync        = flags_q.vsync;
  assign de           = flags_q.de;
  assign line_start   = flags_q.line_start;
  assign frame_start  = flags_q.frame_start;
  assign vblank_start = flags_q.vblank_start;
  assign pixel_x      = x_q;
  assign pixel_y      = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reduced raster for full-frame checks plus a default-timing instance.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HSW = 6, HB = 6;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VA = 12, VF = 2, VSW = 2, VB = 4;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       vb;
  } obs_t;

  typedef struct {
    bit   rst_n;
    bit   ena;
    int   n;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena;
  logic       hs, vs, de, ls, fs, vb;
  logic [9:0] px, py;
  logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
  logic [9:0] d_px, d_py;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) dut (
    .clk_25_175(clk), .rst_n(rst_n), .ena(ena),
    .hsync(hs), .vsync(vs), .de(de), .pixel_x(px), .pixel_y(py),
    .line_start(ls), .frame_start(fs), .vblank_start(vb)
  );

  vga_timing_gen dut_dflt (
    .clk_25_175(clk), .rst_n(rst_n), .ena(ena),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .pixel_x(d_px), .pixel_y(d_py),
    .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb)
  );

  obs_t got, d_got;
  assign got   = {hs, vs, de, px, py, ls, fs, vb};
  assign d_got = {d_hs, d_vs, d_de, d_px, d_py, d_ls, d_fs, d_vb};

  function automatic obs_t o(bit h, bit v, bit d, int x, int y, bit l, bit f, bit b);
    obs_t r;
    r.hs = h; r.vs = v; r.de = d; r.x = 10'(x); r.y = 10'(y);
    r.ls = l; r.fs = f; r.vb = b;
    return r;
  endfunction

  // Reference: pixel p of a frame is (p % HT, p / HT); everything else follows from x/y.
  function automatic obs_t pix_obs(int p, bit stb);
    int x, y;
    x = p % HT;
    y = p / HT;
    return o(!(x >= HA + HF && x < HA + HF + HSW), !(y >= VA + VF && y < VA + VF + VSW),
             (x < HA) && (y < VA), x, y, stb && x == 0, stb && p == 0,
             stb && x == 0 && y == VA);
  endfunction

  // Model: linear pixel index of the next pixel, the one on display, and strobe permission.
  int m_pos = 0, m_shown = 0;
  bit m_rst = 1'b1, m_stb = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0; m_shown <= 0; m_rst <= 1'b1; m_stb <= 1'b0;
    end else if (ena) begin
      m_shown <= m_pos; m_pos <= (m_pos + 1) % FT; m_rst <= 1'b0; m_stb <= 1'b1;
    end else begin
      m_stb <= 1'b0;
    end
  end

  function automatic obs_t model_obs();
    return m_rst ? o(1, 1, 0, 0, 0, 0, 0, 0) : pix_obs(m_shown, m_stb);
  endfunction

  function automatic logic [2:0] dec(logic [9:0] x, logic [9:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    return {!(xi >= HA + HF && xi < HA + HF + HSW), !(yi >= VA + VF && yi < VA + VF + VSW),
            (xi < HA) && (yi < VA)};
  endfunction

  assert property (@(negedge clk) disable iff (!rst_n || m_rst) {hs, vs, de} == dec(px, py))
    else $display("FAIL sva_decode hs/vs/de=%b required=%b", {hs, vs, de}, dec(px, py));

  task automatic check_obs(string nm, obs_t g, obs_t e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b vb=%b required hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b vb=%b",
               nm, g.hs, g.vs, g.de, g.x, g.y, g.ls, g.fs, g.vb,
               e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs, e.vb);
    end
  endtask

  task automatic check_int(string nm, int g, int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", nm, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_obs("model", got, model_obs());
  endtask

  vec_t tv[16];

  initial begin
    int cyc, de_sum, vs_low, hs_low, vb_cnt, ls_cnt;
    rst_n = 1'b0;
    ena   = 1'b1;

    tv[0]  = '{1'b0, 1'b1, 2,   o(1, 1, 0, 0, 0, 0, 0, 0)};
    tv[1]  = '{1'b1, 1'b1, 1,   o(1, 1, 1, 0, 0, 1, 1, 0)};
    tv[2]  = '{1'b1, 1'b1, 15,  o(1, 1, 1, 15, 0, 0, 0, 0)};
    tv[3]  = '{1'b1, 1'b1, 1,   o(1, 1, 0, 16, 0, 0, 0, 0)};
    tv[4]  = '{1'b1, 1'b1, 4,   o(0, 1, 0, 20, 0, 0, 0, 0)};
    tv[5]  = '{1'b1, 1'b1, 5,   o(0, 1, 0, 25, 0, 0, 0, 0)};
    tv[6]  = '{1'b1, 1'b1, 1,   o(1, 1, 0, 26, 0, 0, 0, 0)};
    tv[7]  = '{1'b1, 1'b1, 6,   o(1, 1, 1, 0, 1, 1, 0, 0)};
    tv[8]  = '{1'b1, 1'b0, 5,   o(1, 1, 1, 0, 1, 0, 0, 0)};
    tv[9]  = '{1'b1, 1'b1, 1,   o(1, 1, 1, 1, 1, 0, 0, 0)};
    tv[10] = '{1'b1, 1'b1, 351, o(1, 1, 0, 0, 12, 1, 0, 1)};
    tv[11] = '{1'b1, 1'b1, 64,  o(1, 0, 0, 0, 14, 1, 0, 0)};
    tv[12] = '{1'b1, 1'b1, 63,  o(1, 0, 0, 31, 15, 0, 0, 0)};
    tv[13] = '{1'b1, 1'b1, 1,   o(1, 1, 0, 0, 16, 1, 0, 0)};
    tv[14] = '{1'b1, 1'b1, 127, o(1, 1, 0, 31, 19, 0, 0, 0)};
    tv[15] = '{1'b1, 1'b1, 1,   o(1, 1, 1, 0, 0, 1, 1, 0)};

    for (int i = 0; i < 16; i++) begin
      rst_n = tv[i].rst_n;
      ena   = tv[i].ena;
      repeat (tv[i].n) tick();
      check_obs($sformatf("vec%0d", i), got, tv[i].exp);
    end

    // Default 640x480 timing: first two lines and the start of a third.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
    for (int k = 0; k < 1700; k++) begin
      int x, y;
      tick();
      x = k % 800;
      y = k / 800;
      check_obs("dflt_line", d_got,
                o(!(x >= 656 && x < 752), 1'b1, x < 640, x, y, x == 0, k == 0, 1'b0));
    end

    // Whole-frame statistics on the reduced raster.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_int("fs_first", int'(fs), 1);
    cyc = 0; de_sum = int'(de); vs_low = int'(!vs); hs_low = int'(!hs);
    vb_cnt = int'(vb); ls_cnt = int'(ls);
    while (cyc < 2 * FT) begin
      tick();
      cyc++;
      if (fs) break;
      de_sum += int'(de); vs_low += int'(!vs); hs_low += int'(!hs);
      vb_cnt += int'(vb); ls_cnt += int'(ls);
    end
    check_int("frame_period", cyc, FT);
    check_int("de_sum", de_sum, HA * VA);
    check_int("vsync_low", vs_low, VSW * HT);
    check_int("hsync_low", hs_low, HSW * VT);
    check_int("vblank_cnt", vb_cnt, 1);
    check_int("line_cnt", ls_cnt, VT);

    // Freeze for 37 cycles mid-frame; period must grow by exactly that.
    cyc = 0;
    while (!(px == 10'd10 && py == 10'd5) && cyc < FT) begin
      tick();
      cyc++;
    end
    check_int("reach_x10", int'(px), 10);
    ena = 1'b0;
    for (int k = 0; k < 37; k++) begin
      tick();
      cyc++;
      check_obs("frozen", got, o(1, 1, 1, 10, 5, 0, 0, 0));
    end
    ena = 1'b1;
    tick();
    cyc++;
    check_int("resume_x", int'(px), 11);
    while (cyc < 2 * FT) begin
      tick();
      cyc++;
      if (fs) break;
    end
    check_int("frame_period_ena", cyc, FT + 37);

    // Asynchronous reset in the middle of a frame.
    cyc = 0;
    while (py != 10'd10 && cyc < FT) begin
      tick();
      cyc++;
    end
    check_int("reach_y10", int'(py), 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("async_rst", got, o(1, 1, 0, 0, 0, 0, 0, 0));
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
    check_obs("restart", got, o(1, 1, 1, 0, 0, 1, 1, 0));

    // Random enable gaps and occasional reset pulses against the model.
    for (int k = 0; k < 4000; k++) begin
      ena   = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
